contador_luz_ctrl: RTL and testbench
====================================

Name: contador_luz_ctrl

Overview:
Sequencing controller for the 6-bit item counter (fio) and its indicator lamp (luz). Counts qualified item pulses up to a programmable limit, wraps to zero, toggles luz on every wrap, and stops after a programmed number of lamp toggles. Sits between the item-detect front end and the lamp/display logic, and owns all counter run/pause/abort sequencing.

Parameters:
W, 6, counter width (fio, limit)
TERM_RST, 63, reset value of the limit register (all-ones for W=6)
CW, 8, width of the wrap-cycle counter and cycle target
N_CYC_RST, 4, reset value of the cycle target

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle command: IDLE/FIM->RUN, PAUSA->RUN
stop  in  1  1-cycle command: RUN->PAUSA, PAUSA->IDLE (abort)
item  in  1  count-enable pulse, one item per high cycle
cfg_valid  in  1  config handshake valid
cfg_ready  out  1  config handshake ready (1 only in IDLE)
cfg_limite  in  W  new limit (terminal count)
cfg_ciclos  in  CW  new cycle target
fio  out  W  current item count
luz  out  1  lamp state, toggles on each wrap
wrap  out  1  1-cycle pulse on the cycle fio returns to 0
ciclos  out  CW  wraps completed since start
busy  out  1  high in RUN or PAUSA
done  out  1  level, high in FIM

Behaviour:
- Reset (async, rst_n=0): state IDLE, fio=0, luz=0, wrap=0, ciclos=0, done=0, busy=0, limite=TERM_RST, target=N_CYC_RST. All outputs registered.
- States: IDLE, RUN, PAUSA, FIM (2-bit encoding).
- IDLE: cfg_ready=1; cfg_valid&cfg_ready loads limite and target in one cycle. start -> RUN, clearing fio and ciclos (luz held). item ignored.
- RUN: item=1 and fio!=limite -> fio+1 next cycle. item=1 and fio==limite -> fio=0, luz toggled, wrap=1 for one cycle, ciclos+1. If that wrap makes ciclos==target -> FIM on the same edge. stop -> PAUSA (an item in the same cycle is still counted).
- PAUSA: fio, ciclos and luz frozen; item ignored. start -> RUN; stop -> IDLE (abort, fio/ciclos held until next start).
- FIM: done=1, busy=0, item ignored. start -> RUN with fio=0, ciclos=0, done cleared. cfg not accepted (cfg_ready=0).
- start and stop together: stop wins in every state.
- cfg_valid outside IDLE: held off via cfg_ready=0, no side effect.
- limite=0: every item wraps (luz toggles per item). target=0: treated as 1 (FIM after the first wrap).
- ciclos saturates at 2^CW-1 and never wraps.
- Latency: item -> fio update is 1 cycle. Wrap -> luz/wrap is 1 cycle. Final wrap -> done is 1 cycle.
- Reset asserted mid-run: immediate return to reset values. No pending state survives.

Decomposition:
- Package contador_pkg holds the state typedef (IDLE, RUN, PAUSA, FIM), default W/CW, and TERM_RST.
- Sub-module contador_item: W-bit counter with en, clr and limit inputs, producing a wrap pulse.
- The controller FSM, luz toggle, ciclos counter and config registers stay in contador_luz_ctrl.

Test Plan:
1. Reset, then start, then 64 consecutive item pulses with defaults: fio runs 0..63 and returns to 0. wrap is pulsed once, luz=1, ciclos=1.
2. cfg_limite=9, cfg_ciclos=3 in IDLE, then start and 30 items: luz toggles at items 10, 20 and 30. done=1 one cycle after item 30. Further items leave fio=0.
3. Mid-count stop at fio=5, then 10 items, then start, then 2 items: fio stays 5 through the pause and ends at 7.
4. start and stop asserted together in RUN: state becomes PAUSA. Asserted together in IDLE: state stays IDLE. cfg_valid during RUN: cfg_ready=0 and limite unchanged.
5. limite=0, target=0: the first item gives wrap=1, luz toggles and done=1. A later start restarts with ciclos=0.
6. rst_n pulled low asynchronously mid-cycle at fio=40, luz=1: all outputs go to reset values immediately, and limite reverts to 63.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types and default sizing for the item counter / lamp controller.
package contador_pkg;

  localparam int W_DEF         = 6;
  localparam int CW_DEF        = 8;
  localparam int TERM_RST_DEF  = 63;
  localparam int N_CYC_RST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSA = 2'd2,
    FIM   = 2'd3
  } state_t;

endpackage

// File: rtl/contador_item.sv
// W-bit item counter: counts enabled cycles up to limit, then returns to zero
// with a registered one-cycle wrap pulse.
module contador_item #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         hit,
  output logic         wrap
);

  // hit is the combinational "this count wraps" flag the controller needs on
  // the same edge that cnt returns to zero.
  assign hit = en && (cnt == limit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (hit) begin
      cnt  <= '0;
      wrap <= 1'b1;
    end else begin
      wrap <= 1'b0;
      if (en) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/contador_luz_ctrl.sv
// Run/pause/abort sequencing for the item counter, lamp toggle on each wrap,
// wrap-cycle counting toward a programmable target, and config registers.
module contador_luz_ctrl
  import contador_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int TERM_RST  = TERM_RST_DEF,
  parameter int CW        = CW_DEF,
  parameter int N_CYC_RST = N_CYC_RST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          item,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_limite,
  input  logic [CW-1:0] cfg_ciclos,
  output logic [W-1:0]  fio,
  output logic          luz,
  output logic          wrap,
  output logic [CW-1:0] ciclos,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [W-1:0]  limite;
  logic [CW-1:0] target;
  logic [CW-1:0] tgt_eff;
  logic [CW-1:0] ciclos_inc;
  logic          cnt_en;
  logic          cnt_clr;
  logic          hit;

  assign cnt_en     = item && (state == RUN);
  // A fresh run (from IDLE or FIM) restarts the count; resuming from PAUSA does not.
  assign cnt_clr    = start && !stop && ((state == IDLE) || (state == FIM));
  assign tgt_eff    = (target == '0) ? CW'(1) : target;
  assign ciclos_inc = (ciclos == '1) ? ciclos : ciclos + 1'b1;

  contador_item #(.W(W)) u_item (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .limit (limite),
    .cnt   (fio),
    .hit   (hit),
    .wrap  (wrap)
  );

  // NOTE: status outputs are assigned on the same edge as the state change, so
  // they are plain flops rather than decodes of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      luz       <= 1'b0;
      ciclos    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
      limite    <= W'(TERM_RST);
      target    <= CW'(N_CYC_RST);
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            limite <= cfg_limite;
            target <= cfg_ciclos;
          end
          if (start && !stop) begin
            state     <= RUN;
            ciclos    <= '0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        RUN: begin
          if (hit) begin
            luz    <= ~luz;
            ciclos <= ciclos_inc;
          end
          // Reaching the target completes the run even if stop arrives together.
          if (hit && (ciclos_inc == tgt_eff)) begin
            state <= FIM;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (stop) begin
            state <= PAUSA;
          end
        end
        PAUSA: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (start) begin
            state <= RUN;
          end
        end
        FIM: begin
          if (start && !stop) begin
            state  <= RUN;
            ciclos <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_luz_ctrl.sv
// Self-checking bench for contador_luz_ctrl: stepped vectors with expected
// outputs queued at drive time and compared one cycle later.
module tb_contador_luz_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, item, cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_limite;
  logic [7:0] cfg_ciclos;
  logic [5:0] fio;
  logic       luz, wrap, busy, done;
  logic [7:0] ciclos;

  typedef struct packed {
    logic [5:0] fio;
    logic       luz;
    logic       wrap;
    logic [7:0] ciclos;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  typedef struct {
    string nm;
    bit    s, p, it, cv;
    int    l, c;
    exp_t  e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[8];
  int   n_vec  = 0;
  int   n_miss = 0;

  contador_luz_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .item       (item),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_limite (cfg_limite),
    .cfg_ciclos (cfg_ciclos),
    .fio        (fio),
    .luz        (luz),
    .wrap       (wrap),
    .ciclos     (ciclos),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(int f, bit l, bit w, int c, bit b, bit d, bit r);
    exp_t e;
    e.fio    = f[5:0];
    e.luz    = l;
    e.wrap   = w;
    e.ciclos = c[7:0];
    e.busy   = b;
    e.done   = d;
    e.rdy    = r;
    return e;
  endfunction

  task automatic check(string nm, exp_t e);
    exp_t a;
    a.fio    = fio;
    a.luz    = luz;
    a.wrap   = wrap;
    a.ciclos = ciclos;
    a.busy   = busy;
    a.done   = done;
    a.rdy    = cfg_ready;
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got fio=%0d luz=%b wrap=%b ciclos=%0d busy=%b done=%b rdy=%b, want fio=%0d luz=%b wrap=%b ciclos=%0d busy=%b done=%b rdy=%b",
               nm, a.fio, a.luz, a.wrap, a.ciclos, a.busy, a.done, a.rdy,
               e.fio, e.luz, e.wrap, e.ciclos, e.busy, e.done, e.rdy);
    end
  endtask

  // Drive one cycle of inputs, queue its expected result, compare after the edge.
  task automatic step(string nm, bit s, bit p, bit it, bit cv, int l, int c, exp_t e);
    start      = s;
    stop       = p;
    item       = it;
    cfg_valid  = cv;
    cfg_limite = l[5:0];
    cfg_ciclos = c[7:0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(nm, sb_q.pop_front());
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; item = 0; cfg_valid = 0; cfg_limite = 0; cfg_ciclos = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Stop/start corner cases, config hold-off, and ignored items.
    tbl[0] = '{"t4_cfg_in_run",   0, 0, 0, 1, 7, 1, mk(7, 0, 0, 0, 1, 0, 0)};
    tbl[1] = '{"t4_item_after",   0, 0, 1, 0, 0, 0, mk(8, 0, 0, 0, 1, 0, 0)};
    tbl[2] = '{"t4_both_run",     1, 1, 1, 0, 0, 0, mk(9, 0, 0, 0, 1, 0, 0)};
    tbl[3] = '{"t4_item_pausa",   0, 0, 1, 0, 0, 0, mk(9, 0, 0, 0, 1, 0, 0)};
    tbl[4] = '{"t4_both_pausa",   1, 1, 0, 0, 0, 0, mk(9, 0, 0, 0, 0, 0, 1)};
    tbl[5] = '{"t4_both_idle",    1, 1, 0, 0, 0, 0, mk(9, 0, 0, 0, 0, 0, 1)};
    tbl[6] = '{"t4_item_idle",    0, 0, 1, 0, 0, 0, mk(9, 0, 0, 0, 0, 0, 1)};
    tbl[7] = '{"t5_cfg_zero",     0, 0, 0, 1, 0, 0, mk(9, 0, 0, 0, 0, 0, 1)};

    #12;
    check("reset_state", mk(0, 0, 0, 0, 0, 0, 1));
    #1 rst_n = 1'b1;

    // Test 1: default limit 63, 64 items.
    step("t1_idle", 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
    step("t1_start", 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 63; k++)
      step($sformatf("t1_item%0d", k), 0, 0, 1, 0, 0, 0, mk(k, 0, 0, 0, 1, 0, 0));
    step("t1_wrap", 0, 0, 1, 0, 0, 0, mk(0, 1, 1, 1, 1, 0, 0));
    step("t1_post", 0, 0, 0, 0, 0, 0, mk(0, 1, 0, 1, 1, 0, 0));
    step("t1_pause", 0, 1, 0, 0, 0, 0, mk(0, 1, 0, 1, 1, 0, 0));
    step("t1_abort", 0, 1, 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 0, 1));

    // Test 2: limit 9, target 3, 30 items then extra items in FIM.
    step("t2_cfg", 0, 0, 0, 1, 9, 3, mk(0, 1, 0, 1, 0, 0, 1));
    step("t2_start", 1, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 30; k++) begin
      int f, c;
      bit w, l, fin;
      f   = k % 10;
      c   = k / 10;
      w   = (f == 0);
      l   = 1'b1 ^ c[0];
      fin = (k == 30);
      step($sformatf("t2_item%0d", k), 0, 0, 1, 0, 0, 0, mk(f, l, w, c, !fin, fin, 0));
    end
    for (int k = 0; k < 3; k++)
      step($sformatf("t2_fim_item%0d", k), 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 3, 0, 1, 0));
    step("t2_cfg_in_fim", 0, 0, 0, 1, 3, 1, mk(0, 0, 0, 3, 0, 1, 0));

    // Test 3: pause at fio=5, ignored items, resume.
    step("t3_start", 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 5; k++)
      step($sformatf("t3_item%0d", k), 0, 0, 1, 0, 0, 0, mk(k, 0, 0, 0, 1, 0, 0));
    step("t3_stop", 0, 1, 0, 0, 0, 0, mk(5, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 10; k++)
      step($sformatf("t3_paused%0d", k), 0, 0, 1, 0, 0, 0, mk(5, 0, 0, 0, 1, 0, 0));
    step("t3_resume", 1, 0, 0, 0, 0, 0, mk(5, 0, 0, 0, 1, 0, 0));
    step("t3_item6", 0, 0, 1, 0, 0, 0, mk(6, 0, 0, 0, 1, 0, 0));
    step("t3_item7", 0, 0, 1, 0, 0, 0, mk(7, 0, 0, 0, 1, 0, 0));

    // Test 4 (+ start of 5): table-driven.
    foreach (tbl[i])
      step(tbl[i].nm, tbl[i].s, tbl[i].p, tbl[i].it, tbl[i].cv, tbl[i].l, tbl[i].c, tbl[i].e);

    // Test 5: limit 0, target 0 -> first item finishes the run.
    step("t5_start", 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    step("t5_item", 0, 0, 1, 0, 0, 0, mk(0, 1, 1, 1, 0, 1, 0));
    step("t5_fim_item", 0, 0, 1, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 0));
    step("t5_restart", 1, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 0));
    step("t5_item2", 0, 0, 1, 0, 0, 0, mk(0, 0, 1, 1, 0, 1, 0));

    // Test 6 setup: get luz=1 and fio=40 under a wide limit.
    step("t6_start", 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    step("t6_pause", 0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    step("t6_abort", 0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
    step("t6_cfg_a", 0, 0, 0, 1, 0, 2, mk(0, 0, 0, 0, 0, 0, 1));
    step("t6_start_a", 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    step("t6_wrap_a", 0, 0, 1, 0, 0, 0, mk(0, 1, 1, 1, 1, 0, 0));
    step("t6_pause_a", 0, 1, 0, 0, 0, 0, mk(0, 1, 0, 1, 1, 0, 0));
    step("t6_abort_a", 0, 1, 0, 0, 0, 0, mk(0, 1, 0, 1, 0, 0, 1));
    step("t6_cfg_b", 0, 0, 0, 1, 50, 4, mk(0, 1, 0, 1, 0, 0, 1));
    step("t6_start_b", 1, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 40; k++)
      step($sformatf("t6_item%0d", k), 0, 0, 1, 0, 0, 0, mk(k, 1, 0, 0, 1, 0, 0));
    idle_inputs();
    #3 rst_n = 1'b0;
    #1 check("t6_async_rst", mk(0, 0, 0, 0, 0, 0, 1));
    #2 rst_n = 1'b1;

    // Limit must be back to 63 and target back to 4.
    step("t6_rel_idle", 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
    step("t6_restart", 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 63; k++)
      step($sformatf("t6_ritem%0d", k), 0, 0, 1, 0, 0, 0, mk(k, 0, 0, 0, 1, 0, 0));
    step("t6_rwrap", 0, 0, 1, 0, 0, 0, mk(0, 1, 1, 1, 1, 0, 0));
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
